// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative RV32M multiply/divide execution unit.
//
// Sits beside the single-cycle ALU, downstream of the decoder. When the
// decoder flags an M-extension instruction (start) in IDLE, the operands are
// captured as magnitudes along with the result sign. The unit then runs
// 32 iterations (shift-add multiply or restoring divide) and presents the
// sign-corrected result for one cycle on valid. It holds PC/ID through
// stall while the operation is in flight.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   start     M-extension instruction present (sampled only in IDLE)
//   op        funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1_data  operand A (multiplicand / dividend)
//   rs2_data  operand B (multiplier / divisor)
//   rd_i      destination register index
//   flush     synchronous kill of the in-flight operation
//   busy      high while iterating (CALC)
//   stall     hold PC/ID (combinational)
//   valid     one-cycle result strobe (DONE)
//   result    result word, held in IDLE
//   rd_o      captured destination index, aligned with valid
module ex_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_i,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] m_q;       // multiplicand (mul) or divisor (div)
  logic [XLEN-1:0] hi_q;      // product high half / partial remainder
  logic [XLEN-1:0] lo_q;      // multiplier / dividend, becomes product low / quotient
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic            dz_q;
  logic            ovf_q;
  logic [XLEN-1:0] result_q;

  // Operand decode at capture time
  logic            a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_in, dz_in, ovf_in;

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'd2: a_sgn = 1'b1;
      default: begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
      end
    endcase
    sa     = a_sgn & rs1_data[XLEN-1];
    sb     = b_sgn & rs2_data[XLEN-1];
    // abs(MIN_NEG) wraps to itself, which is the correct unsigned 2^(XLEN-1)
    a_mag  = sa ? -rs1_data : rs1_data;
    b_mag  = sb ? -rs2_data : rs2_data;
    neg_in = (op[2] & op[1]) ? sa : (sa ^ sb);
    dz_in  = (rs2_data == '0);
    ovf_in = ((op == 3'd4) || (op == 3'd6)) && (rs1_data == MIN_NEG) && (rs2_data == '1);
  end

  // One iteration of either algorithm
  logic [XLEN:0]     add;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_d;
  logic              last;

  always_comb begin
    add     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    trial   = shifted - {1'b0, m_q};
    if (op_q[2]) begin
      // Restoring divide: a clear borrow bit means the trial subtract fits
      if (!trial[XLEN]) begin
        hi_nx = trial[XLEN-1:0];
        lo_nx = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = shifted[XLEN-1:0];
        lo_nx = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = add[XLEN:1];
      lo_nx = {add[0], lo_q[XLEN-1:1]};
    end

    prod     = {hi_nx, lo_nx};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_nx : lo_nx;
    // With a zero divisor the remainder ends up holding |A|; fixing it up
    // with A's sign reproduces A's original bit pattern.
    rem_fix  = neg_q ? -hi_nx : hi_nx;

    case (op_q)
      3'd0:             res_d = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res_d = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res_d = quo_fix;
      default:          res_d = rem_fix;
    endcase
    if (op_q[2] && !op_q[1]) begin
      if (dz_q)       res_d = '1;
      else if (ovf_q) res_d = MIN_NEG;
    end
    if (op_q[2] && op_q[1] && ovf_q) res_d = '0;

    last = (cnt_q == CW'(XLEN - 1));
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = CALC;
        CALC:    if (last)  state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= '0;
      rd_q     <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else if (!flush) begin
      if (state_q == IDLE && start) begin
        op_q  <= op;
        rd_q  <= rd_i;
        m_q   <= op[2] ? b_mag : a_mag;
        lo_q  <= op[2] ? a_mag : b_mag;
        hi_q  <= '0;
        cnt_q <= '0;
        neg_q <= neg_in;
        dz_q  <= dz_in;
        ovf_q <= ovf_in;
      end else if (state_q == CALC) begin
        hi_q  <= hi_nx;
        lo_q  <= lo_nx;
        cnt_q <= cnt_q + 1'b1;
        if (last) result_q <= res_d;
      end
    end
  end

  assign busy   = (state_q == CALC);
  assign valid  = (state_q == DONE);
  assign stall  = (start && (state_q == IDLE)) || (state_q == CALC);
  assign result = result_q;
  assign rd_o   = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Testbench for ex_muldiv: table of directed vectors, handshake corner
// sequences and random operations against a behavioural reference.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_i = '0;
  logic        flush = 1'b0;
  logic        busy, stall, valid;
  logic [31:0] result;
  logic [4:0]  rd_o;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_i(rd_i), .flush(flush),
    .busy(busy), .stall(stall), .valid(valid), .result(result), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned cyc;
  } exp_t;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  vec_t        tbl[20];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa64, sb64, ub64, p;
    logic signed [31:0] q;
    logic               ovf;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ub64 = {32'b0, b};
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa64 * sb64; return p[31:0]; end
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * ub64; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Scoreboard: each valid must match the oldest pending op, 32 cycles after its start edge
  always @(negedge clk) begin
    if (rst && valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got result %h rd %0d with no pending op", result, rd_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", result, mon_e.res);
        chk("rd_o", {27'b0, rd_o}, {27'b0, mon_e.rd});
        chk("latency", cyc - mon_e.cyc, 32);
      end
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 100 && (busy || valid); i++) @(negedge clk);
    if (busy || valid) fail_now("wait_idle");
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp,
                       input int unsigned repulse_at, input int unsigned post_wait);
    exp_t        e;
    int unsigned nst;
    bit          seen;
    wait_idle();
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_i = rd;
    e.res = exp; e.rd = rd; e.cyc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; rd_i = 5'($urandom);
    op = 3'($urandom);
    nst = 0;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1;
        break;
      end
      if (stall) nst++;
      start = (repulse_at != 0) && (i == repulse_at);
      if (start) begin
        rs1_data = $urandom; rs2_data = $urandom; rd_i = 5'($urandom);
      end
    end
    start = 1'b0;
    if (!seen) begin
      fail_now("valid_timeout");
      sb_q.delete();
    end else begin
      chk("stall_at_valid", {31'b0, stall}, 32'd0);
      chk("stall_cycles", nst, 32);
    end
    repeat (post_wait) @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB};
    tbl[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000};
    tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd7,  32'hFFFF_FFFD};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF};
    tbl[6]  = '{3'd5, 32'd100,       32'd7,         5'd9,  32'd14};
    tbl[7]  = '{3'd7, 32'd100,       32'd7,         5'd10, 32'd2};
    tbl[8]  = '{3'd5, 32'd100,       32'd0,         5'd11, 32'hFFFF_FFFF};
    tbl[9]  = '{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd12, 32'hFFFF_FFF9};
    tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000};
    tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000};
    tbl[12] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD};
    tbl[13] = '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 5'd16, 32'h0000_0001};
    tbl[14] = '{3'd3, 32'h8000_0000, 32'h0000_0002, 5'd17, 32'h0000_0001};
    tbl[15] = '{3'd4, 32'h8000_0000, 32'd0,         5'd18, 32'hFFFF_FFFF};
    tbl[16] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 5'd21, 32'h0000_0000};
    tbl[17] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 32'h0000_0000};
    tbl[18] = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0010, 5'd19, 32'h0FFF_FFFF};
    tbl[19] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 5'd20, 32'h0000_000F};

    // Reset state
    #1;
    chk("reset_busy",   {31'b0, busy},  32'd0);
    chk("reset_valid",  {31'b0, valid}, 32'd0);
    chk("reset_stall",  {31'b0, stall}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd_o",   {27'b0, rd_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 20; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, 0, 2);

    // Asynchronous reset mid-operation: no result, everything cleared at once
    wait_idle();
    start = 1'b1; op = 3'd0; rs1_data = 32'd12345; rs2_data = 32'd678; rd_i = 5'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy",   {31'b0, busy},  32'd0);
    chk("async_rst_valid",  {31'b0, valid}, 32'd0);
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_rd_o",   {27'b0, rd_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 0, 2);

    // Flush five cycles into CALC
    wait_idle();
    start = 1'b1; op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; rd_i = 5'd23;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_busy",  {31'b0, busy},  32'd0);
    chk("flush_valid", {31'b0, valid}, 32'd0);
    repeat (40) @(negedge clk);

    // start and flush together in IDLE: not accepted
    wait_idle();
    start = 1'b1; flush = 1'b1; op = 3'd5; rs1_data = 32'd50; rs2_data = 32'd5; rd_i = 5'd24;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Re-pulsed start during CALC is ignored; exactly one valid
    do_op(3'd7, 32'd100, 32'd7, 5'd25, 32'd2, 5, 36);

    // Back-to-back: start held through DONE, second op accepted at E34
    begin
      exp_t        e;
      int unsigned s0;
      wait_idle();
      start = 1'b1; op = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7; rd_i = 5'd1;
      s0 = cyc + 1;
      e.res = 32'd14; e.rd = 5'd1; e.cyc = s0;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      op = 3'd0; rs1_data = 32'h0000_0007; rs2_data = 32'hFFFF_FFFD; rd_i = 5'd2;
      e.res = 32'hFFFF_FFEB; e.rd = 5'd2; e.cyc = s0 + 34;
      sb_q.push_back(e);
      repeat (34) @(posedge clk);
      #1 start = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
      for (int i = 0; i < 45 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
        fail_now("back_to_back_timeout");
        sb_q.delete();
      end
      repeat (2) @(negedge clk);
    end

    // Random operations against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, 5'($urandom), ref_model(ro, ra, rb), 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
